// File: rtl/sat_pkg.sv
// Shared definitions for the SAT engine clause sequencing blocks.
//   state_t       : loader sequencer states
//   IDX_W         : slot index width for the default array size
//   CLAUSE_W      : clause word width (two bits per variable) for the default size
//   idx_width()   : slot index width for an arbitrary array size
//   clause_width(): clause word width for an arbitrary variable count
package sat_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_WAIT,
        S_LD_WR,
        S_UL_RD,
        S_UL_CAP,
        S_UL_WR,
        S_DONE,
        S_LD_ZF
    } state_t;

    localparam int unsigned NUM_CLAUSES_DEF = 8;
    localparam int unsigned NUM_VARS_DEF    = 8;
    localparam int unsigned IDX_W           = $clog2(NUM_CLAUSES_DEF);
    localparam int unsigned CLAUSE_W        = NUM_VARS_DEF * 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned clause_width(input int unsigned nv);
        return nv * 2;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary slot index to one-hot slot vector decoder.
//   idx    : slot index
//   onehot : NUM_CLAUSES-bit vector with bit idx set
module onehot_dec #(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned IDX_W       = 3
) (
    input  logic [IDX_W-1:0]       idx,
    output logic [NUM_CLAUSES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/clause_array_loader.sv
// Moves one bin of clauses between bin memory and the clause array.
// Load: fetch clause base+idx from memory (req/ack), write it to slot idx.
// Unload: read slot idx (data one cycle after strobe), write it to base+idx.
// Optional build macro CLAUSE_ARRAY_LOADER_ZERO_FILL_EN: after a load, the
// slots beyond the loaded count are written with zero clause / zero length.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   load_start_i        : start load (IDLE only, wins over unload)
//   unload_start_i      : start unload (IDLE only)
//   base_addr_i         : memory address of clause 0, captured at start
//   clause_cnt_i        : clauses to move, captured at start, clamped to NUM_CLAUSES
//   busy_o, done_o      : not-IDLE flag, one-cycle completion pulse
//   mem_rd_*            : memory read request/address/ack/data/length
//   mem_wr_*            : memory write strobe/address/data
//   arr_wr_o, arr_rd_o  : one-hot slot write/read strobes
//   arr_clause_o/_len_o : clause and length to the array
//   arr_clause_i        : clause read back from the array
module clause_array_loader
    import sat_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_C_LEN = 4,
    parameter int unsigned WIDTH_ADDR  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start_i,
    input  logic                          unload_start_i,
    input  logic [WIDTH_ADDR-1:0]         base_addr_i,
    input  logic [$clog2(NUM_CLAUSES):0]  clause_cnt_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          mem_rd_req_o,
    output logic [WIDTH_ADDR-1:0]         mem_rd_addr_o,
    input  logic                          mem_rd_ack_i,
    input  logic [NUM_VARS*2-1:0]         mem_rd_clause_i,
    input  logic [WIDTH_C_LEN-1:0]        mem_rd_len_i,
    output logic                          mem_wr_o,
    output logic [WIDTH_ADDR-1:0]         mem_wr_addr_o,
    output logic [NUM_VARS*2-1:0]         mem_wr_clause_o,
    output logic [NUM_CLAUSES-1:0]        arr_wr_o,
    output logic [NUM_CLAUSES-1:0]        arr_rd_o,
    output logic [NUM_VARS*2-1:0]         arr_clause_o,
    output logic [WIDTH_C_LEN-1:0]        arr_clause_len_o,
    input  logic [NUM_VARS*2-1:0]         arr_clause_i
);

    localparam int unsigned IW    = idx_width(NUM_CLAUSES);
    localparam int unsigned CNT_W = IW + 1;
    localparam int unsigned CW    = clause_width(NUM_VARS);

    state_t                 state, state_next;
    logic [WIDTH_ADDR-1:0]  base_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IW-1:0]          idx_q;
    logic [CW-1:0]          clause_q;
    logic [WIDTH_C_LEN-1:0] len_q;
    logic                   done_q;

    logic [CNT_W-1:0]       cnt_clamped;
    logic                   start_any;
    logic                   last;
    logic                   idx_top;
    logic [NUM_CLAUSES-1:0] slot_onehot;
    logic [WIDTH_ADDR-1:0]  cur_addr;

    assign cnt_clamped = (clause_cnt_i > CNT_W'(NUM_CLAUSES)) ? CNT_W'(NUM_CLAUSES) : clause_cnt_i;
    assign start_any   = load_start_i | unload_start_i;
    assign last        = (CNT_W'(idx_q) == cnt_q - CNT_W'(1));
    assign idx_top     = (idx_q == IW'(NUM_CLAUSES - 1));
    assign cur_addr    = base_q + WIDTH_ADDR'(idx_q);

    onehot_dec #(
        .NUM_CLAUSES(NUM_CLAUSES),
        .IDX_W      (IW)
    ) u_dec (
        .idx   (idx_q),
        .onehot(slot_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load_start_i) begin
                    if (cnt_clamped == '0) begin
`ifdef CLAUSE_ARRAY_LOADER_ZERO_FILL_EN
                        state_next = S_LD_ZF;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_LD_REQ;
                    end
                end else if (unload_start_i) begin
                    state_next = (cnt_clamped == '0) ? S_DONE : S_UL_RD;
                end
            end
            S_LD_REQ:  state_next = S_LD_WAIT;
            S_LD_WAIT: if (mem_rd_ack_i) state_next = S_LD_WR;
            S_LD_WR: begin
                if (last) begin
`ifdef CLAUSE_ARRAY_LOADER_ZERO_FILL_EN
                    // a full bin has no slots left to clear
                    state_next = idx_top ? S_DONE : S_LD_ZF;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_LD_REQ;
                end
            end
            S_LD_ZF:  state_next = idx_top ? S_DONE : S_LD_ZF;
            S_UL_RD:  state_next = S_UL_CAP;
            S_UL_CAP: state_next = S_UL_WR;
            S_UL_WR:  state_next = last ? S_DONE : S_UL_RD;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath registers: captured parameters, slot index, staged clause.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            clause_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start_any) begin
                        base_q <= base_addr_i;
                        cnt_q  <= cnt_clamped;
                        idx_q  <= '0;
                    end
                end
                S_LD_WAIT: begin
                    if (mem_rd_ack_i) begin
                        clause_q <= mem_rd_clause_i;
                        len_q    <= mem_rd_len_i;
                    end
                end
                S_UL_CAP: clause_q <= arr_clause_i;
                S_LD_WR, S_LD_ZF, S_UL_WR: idx_q <= idx_q + IW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o           = (state != S_IDLE);
        done_o           = done_q;
        mem_rd_req_o     = 1'b0;
        mem_rd_addr_o    = '0;
        mem_wr_o         = 1'b0;
        mem_wr_addr_o    = '0;
        mem_wr_clause_o  = '0;
        arr_wr_o         = '0;
        arr_rd_o         = '0;
        arr_clause_o     = '0;
        arr_clause_len_o = '0;
        case (state)
            S_LD_REQ: begin
                mem_rd_req_o  = 1'b1;
                mem_rd_addr_o = cur_addr;
            end
            S_LD_WR: begin
                arr_wr_o         = slot_onehot;
                arr_clause_o     = clause_q;
                arr_clause_len_o = len_q;
            end
            S_LD_ZF: arr_wr_o = slot_onehot;
            S_UL_RD: arr_rd_o = slot_onehot;
            S_UL_WR: begin
                mem_wr_o        = 1'b1;
                mem_wr_addr_o   = cur_addr;
                mem_wr_clause_o = clause_q;
            end
            default: ;
        endcase
    end

endmodule
